// File: rtl/uint16_ram_mover.sv
// FILL/COPY engine driving a 32-word synchronous RAM through a registered Moore interface.
// Optional running checksum of written words is enabled by defining CHECKSUM_EN.
module uint16_ram_mover (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        op,
   input  logic [15:0] src,
   input  logic [15:0] dst,
   input  logic [5:0]  length,
   input  logic [15:0] fill_value,
   output logic        busy,
   output logic        done,
   output logic [15:0] checksum,
   output logic [15:0] ram_address,
   output logic        ram_read,
   output logic        ram_write,
   output logic [15:0] ram_input_data,
   input  logic [15:0] ram_output_data
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FILL_WR = 3'd1,
      CP_RD   = 3'd2,
      CP_CAP  = 3'd3,
      CP_WR   = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t      state_reg, state_next;
   logic [5:0]  i_reg, i_next;
   logic [5:0]  len_reg, len_next;
   logic [15:0] src_reg, src_next;
   logic [15:0] dst_reg, dst_next;
   logic [15:0] fill_reg, fill_next;
   logic [15:0] hold_reg, hold_next;

   logic        busy_reg, busy_next;
   logic        done_reg, done_next;
   logic [15:0] addr_reg, addr_next;
   logic        rd_reg, rd_next;
   logic        wr_reg, wr_next;
   logic [15:0] wdata_reg, wdata_next;

   logic [5:0]  len_clamped;
   logic [5:0]  i_inc;
   logic [15:0] i_ext;

   assign len_clamped = (length > 6'd32) ? 6'd32 : length;
   assign i_inc       = i_reg + 6'd1;
   assign i_ext       = {10'd0, i_next};

   always_comb begin
      state_next = state_reg;
      i_next     = i_reg;
      len_next   = len_reg;
      src_next   = src_reg;
      dst_next   = dst_reg;
      fill_next  = fill_reg;
      hold_next  = hold_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               src_next  = src;
               dst_next  = dst;
               fill_next = fill_value;
               len_next  = len_clamped;
               i_next    = 6'd0;
               if (len_clamped == 6'd0)
                  state_next = DONE;
               else if (op)
                  state_next = CP_RD;
               else
                  state_next = FILL_WR;
            end
         end
         FILL_WR: begin
            i_next = i_inc;
            if (i_inc == len_reg)
               state_next = DONE;
         end
         CP_RD: begin
            state_next = CP_CAP;
         end
         CP_CAP: begin
            // read data is valid during this cycle, one cycle after the read strobe
            hold_next  = ram_output_data;
            state_next = CP_WR;
         end
         CP_WR: begin
            i_next     = i_inc;
            state_next = (i_inc == len_reg) ? DONE : CP_RD;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they appear registered alongside it.
   always_comb begin
      busy_next  = 1'b0;
      done_next  = 1'b0;
      addr_next  = 16'd0;
      rd_next    = 1'b0;
      wr_next    = 1'b0;
      wdata_next = 16'd0;
      case (state_next)
         FILL_WR: begin
            busy_next  = 1'b1;
            wr_next    = 1'b1;
            addr_next  = dst_next + i_ext;
            wdata_next = fill_next;
         end
         CP_RD: begin
            busy_next = 1'b1;
            rd_next   = 1'b1;
            addr_next = src_next + i_ext;
         end
         CP_CAP: begin
            busy_next = 1'b1;
         end
         CP_WR: begin
            busy_next  = 1'b1;
            wr_next    = 1'b1;
            addr_next  = dst_next + i_ext;
            wdata_next = hold_next;
         end
         DONE: begin
            done_next = 1'b1;
         end
         default: begin
            busy_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         i_reg     <= 6'd0;
         len_reg   <= 6'd0;
         src_reg   <= 16'd0;
         dst_reg   <= 16'd0;
         fill_reg  <= 16'd0;
         hold_reg  <= 16'd0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         addr_reg  <= 16'd0;
         rd_reg    <= 1'b0;
         wr_reg    <= 1'b0;
         wdata_reg <= 16'd0;
      end else begin
         state_reg <= state_next;
         i_reg     <= i_next;
         len_reg   <= len_next;
         src_reg   <= src_next;
         dst_reg   <= dst_next;
         fill_reg  <= fill_next;
         hold_reg  <= hold_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         addr_reg  <= addr_next;
         rd_reg    <= rd_next;
         wr_reg    <= wr_next;
         wdata_reg <= wdata_next;
      end
   end

   assign busy           = busy_reg;
   assign done           = done_reg;
   assign ram_address    = addr_reg;
   assign ram_read       = rd_reg;
   assign ram_write      = wr_reg;
   assign ram_input_data = wdata_reg;

`ifdef CHECKSUM_EN
   logic [15:0] checksum_reg, checksum_next;

   // The word being written in FILL_WR/CP_WR is summed at that cycle's closing edge.
   always_comb begin
      checksum_next = checksum_reg;
      if (state_reg == IDLE && start)
         checksum_next = 16'd0;
      else if (state_reg == FILL_WR)
         checksum_next = checksum_reg + fill_reg;
      else if (state_reg == CP_WR)
         checksum_next = checksum_reg + hold_reg;
   end

   always_ff @(posedge clk) begin
      if (rst)
         checksum_reg <= 16'd0;
      else
         checksum_reg <= checksum_next;
   end

   assign checksum = checksum_reg;
`else
   assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_uint16_ram_mover.sv
// Self-checking bench for uint16_ram_mover: RAM model plus write scoreboard.
module tb_uint16_ram_mover;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [15:0] src = 16'd0;
   logic [15:0] dst = 16'd0;
   logic [5:0]  length = 6'd0;
   logic [15:0] fill_value = 16'd0;
   logic        busy, done;
   logic [15:0] checksum, ram_address, ram_input_data;
   logic        ram_read, ram_write;
   logic [15:0] ram_output_data = 16'd0;

`ifdef CHECKSUM_EN
   localparam bit CKS_EN = 1'b1;
`else
   localparam bit CKS_EN = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:31];
   logic [15:0] shadow [0:31];
   logic        pre_we = 1'b0;
   logic [4:0]  pre_addr = 5'd0;
   logic [15:0] pre_data = 16'd0;
   logic [31:0] exp_q [$];

   int          r_done_at, r_busy, r_strobes;
   logic [15:0] r_sum, r_cks_done, r_cks_after;
   logic        r_after_busy, r_after_done;

   uint16_ram_mover dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .src(src), .dst(dst),
      .length(length), .fill_value(fill_value), .busy(busy), .done(done),
      .checksum(checksum), .ram_address(ram_address), .ram_read(ram_read),
      .ram_write(ram_write), .ram_input_data(ram_input_data),
      .ram_output_data(ram_output_data)
   );

   always #5 clk = ~clk;

   // RAM: decodes address bits [4:0], read data valid the cycle after ram_read, else 0
   always @(posedge clk) begin
      if (ram_write)
         mem[ram_address[4:0]] <= ram_input_data;
      else if (pre_we)
         mem[pre_addr] <= pre_data;
      ram_output_data <= ram_read ? mem[ram_address[4:0]] : 16'd0;
   end

   always @(negedge clk) begin
      if (ram_read && ram_write) begin
         checks++;
         errors++;
         $display("FAIL strobe_overlap read=%0b write=%0b required not both", ram_read, ram_write);
      end
      if (ram_write) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%h data=%h required no write", ram_address, ram_input_data);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if ({ram_address, ram_input_data} !== e) begin
               errors++;
               $display("FAIL write addr=%h data=%h required addr=%h data=%h",
                        ram_address, ram_input_data, e[31:16], e[15:0]);
            end else
               $display("write addr=%h data=%h ok", ram_address, ram_input_data);
         end
      end
   end

   task automatic preload(input logic [4:0] a, input logic [15:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      shadow[a] = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Drives one command, predicts its writes, and records timing; comparisons are done by callers.
   task automatic run_cmd(input logic op_i, input logic [15:0] src_i, input logic [15:0] dst_i,
                          input logic [5:0] len_i, input logic [15:0] fv_i,
                          input int poke_at, input bit poke_done);
      int n;
      logic [15:0] a, d, v;
      n = (len_i > 6'd32) ? 32 : int'(len_i);
      r_sum = 16'd0;
      for (int k = 0; k < n; k++) begin
         a = src_i + 16'(k);
         d = dst_i + 16'(k);
         v = op_i ? shadow[a[4:0]] : fv_i;
         exp_q.push_back({d, v});
         shadow[d[4:0]] = v;
         r_sum = r_sum + v;
      end
      @(negedge clk);
      start = 1'b1; op = op_i; src = src_i; dst = dst_i; length = len_i; fill_value = fv_i;
      @(negedge clk);
      start = 1'b0; op = ~op_i; src = 16'hFFFF; dst = 16'h7777; length = 6'd9; fill_value = 16'h5555;
      r_done_at = 0; r_busy = 0; r_strobes = 0;
      for (int c = 1; c <= 200; c++) begin
         if (busy) r_busy++;
         if (ram_read || ram_write) r_strobes++;
         start = 1'b0;
         if (c == poke_at) begin
            start = 1'b1; op = 1'b0; dst = 16'd5; length = 6'd7; fill_value = 16'hDEAD;
         end
         if (done) begin
            r_done_at = c;
            r_cks_done = checksum;
            if (poke_done) begin
               start = 1'b1; op = 1'b0; dst = 16'd6; length = 6'd2; fill_value = 16'hBEEF;
            end
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      start = 1'b0;
      r_after_busy = busy;
      r_after_done = done;
      r_cks_after  = checksum;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1; start = 1'b1; op = 1'b1; length = 6'd5;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, checksum, ram_address, ram_read, ram_write, ram_input_data} !== 51'd0) begin
         errors++;
         $display("FAIL reset_outputs busy=%0b done=%0b cks=%h addr=%h rd=%0b wr=%0b wd=%h required all 0",
                  busy, done, checksum, ram_address, ram_read, ram_write, ram_input_data);
      end else
         $display("reset outputs all zero ok");
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_priority busy=%0b done=%0b required 0 0", busy, done);
      end else
         $display("reset priority over start ok");
   endtask

   task automatic test_copy;
      logic [15:0] ek;
      preload(5'd0, 16'd1);
      preload(5'd1, 16'd2);
      preload(5'd2, 16'd3);
      run_cmd(1'b1, 16'd0, 16'd8, 6'd3, 16'd0, 0, 1'b0);
      ek = CKS_EN ? r_sum : 16'd0;
      checks++;
      if (r_done_at !== 10 || r_busy !== 9 || r_strobes !== 6) begin
         errors++;
         $display("FAIL copy_timing done_at=%0d busy=%0d strobes=%0d required 10 9 6", r_done_at, r_busy, r_strobes);
      end else
         $display("copy timing ok");
      checks++;
      if (r_after_done !== 1'b0 || r_after_busy !== 1'b0) begin
         errors++;
         $display("FAIL copy_done_pulse done=%0b busy=%0b required 0 0", r_after_done, r_after_busy);
      end
      checks++;
      if (r_cks_done !== ek || r_cks_after !== ek) begin
         errors++;
         $display("FAIL copy_checksum got=%h/%h required %h", r_cks_done, r_cks_after, ek);
      end else
         $display("copy checksum %h ok", r_cks_done);
      checks++;
      if (mem[8] !== 16'd1 || mem[9] !== 16'd2 || mem[10] !== 16'd3) begin
         errors++;
         $display("FAIL copy_mem got=%h %h %h required 1 2 3", mem[8], mem[9], mem[10]);
      end
   endtask

   task automatic test_fill_wrap;
      logic [15:0] ek;
      run_cmd(1'b0, 16'd0, 16'd30, 6'd4, 16'hABCD, 0, 1'b0);
      ek = CKS_EN ? 16'hAF34 : 16'd0;
      checks++;
      if (r_done_at !== 5 || r_busy !== 4 || r_strobes !== 4) begin
         errors++;
         $display("FAIL fill_timing done_at=%0d busy=%0d strobes=%0d required 5 4 4", r_done_at, r_busy, r_strobes);
      end else
         $display("fill wrap timing ok");
      checks++;
      if (r_cks_done !== ek || r_cks_after !== ek) begin
         errors++;
         $display("FAIL fill_checksum got=%h/%h required %h", r_cks_done, r_cks_after, ek);
      end
      checks++;
      if (mem[30] !== 16'hABCD || mem[31] !== 16'hABCD || mem[0] !== 16'hABCD || mem[1] !== 16'hABCD) begin
         errors++;
         $display("FAIL fill_mem got=%h %h %h %h required abcd x4", mem[30], mem[31], mem[0], mem[1]);
      end
   endtask

   task automatic test_zero_length;
      for (int k = 0; k < 2; k++) begin
         run_cmd(k[0], 16'd3, 16'd12, 6'd0, 16'h1111, 0, 1'b1);
         checks++;
         if (r_done_at !== 1 || r_strobes !== 0 || r_busy !== 0) begin
            errors++;
            $display("FAIL zero_len op=%0d done_at=%0d strobes=%0d busy=%0d required 1 0 0",
                     k, r_done_at, r_strobes, r_busy);
         end else
            $display("zero length op=%0d ok", k);
         checks++;
         if (r_after_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done op=%0d busy=%0b required 0", k, r_after_busy);
         end
      end
   endtask

   task automatic test_clamp;
      run_cmd(1'b0, 16'd0, 16'd4, 6'd40, 16'h0F0F, 0, 1'b0);
      checks++;
      if (r_strobes !== 32 || r_busy !== 32 || r_done_at !== 33) begin
         errors++;
         $display("FAIL clamp strobes=%0d busy=%0d done_at=%0d required 32 32 33", r_strobes, r_busy, r_done_at);
      end else
         $display("clamp to 32 ok");
   endtask

   task automatic test_ignore_start;
      preload(5'd12, 16'hC001);
      preload(5'd13, 16'hC002);
      preload(5'd14, 16'hC003);
      run_cmd(1'b1, 16'd12, 16'd20, 6'd3, 16'd0, 4, 1'b0);
      checks++;
      if (r_done_at !== 10 || r_busy !== 9) begin
         errors++;
         $display("FAIL ignore_start done_at=%0d busy=%0d required 10 9", r_done_at, r_busy);
      end else
         $display("mid-copy start ignored ok");
      checks++;
      if (mem[20] !== 16'hC001 || mem[21] !== 16'hC002 || mem[22] !== 16'hC003 || mem[5] === 16'hDEAD) begin
         errors++;
         $display("FAIL ignore_start_mem got=%h %h %h w5=%h required c001 c002 c003", mem[20], mem[21], mem[22], mem[5]);
      end
   endtask

   task automatic test_rst_mid_copy;
      logic [15:0] ek;
      @(negedge clk);
      start = 1'b1; op = 1'b1; src = 16'd0; dst = 16'd16; length = 6'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || ram_read !== 1'b0 || ram_write !== 1'b0) begin
         errors++;
         $display("FAIL cp_cap_state busy=%0b rd=%0b wr=%0b required 1 0 0", busy, ram_read, ram_write);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, checksum, ram_address, ram_read, ram_write, ram_input_data} !== 51'd0) begin
         errors++;
         $display("FAIL rst_mid_copy busy=%0b done=%0b cks=%h addr=%h rd=%0b wr=%0b wd=%h required all 0",
                  busy, done, checksum, ram_address, ram_read, ram_write, ram_input_data);
      end else
         $display("reset during CP_CAP ok");
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ram_read !== 1'b0 || ram_write !== 1'b0) begin
         errors++;
         $display("FAIL post_rst_idle busy=%0b rd=%0b wr=%0b required 0 0 0", busy, ram_read, ram_write);
      end
      run_cmd(1'b0, 16'd0, 16'd3, 6'd1, 16'h1234, 0, 1'b0);
      ek = CKS_EN ? 16'h1234 : 16'd0;
      checks++;
      if (r_done_at !== 2 || r_busy !== 1 || r_cks_done !== ek || mem[3] !== 16'h1234) begin
         errors++;
         $display("FAIL fill_after_rst done_at=%0d busy=%0d cks=%h mem3=%h required 2 1 %h 1234",
                  r_done_at, r_busy, r_cks_done, mem[3], ek);
      end else
         $display("fill after reset ok");
   endtask

   task automatic test_back_to_back;
      logic [15:0] ek;
      run_cmd(1'b0, 16'd0, 16'd24, 6'd2, 16'h8001, 0, 1'b0);
      run_cmd(1'b1, 16'd24, 16'd25, 6'd3, 16'd0, 0, 1'b0);
      ek = CKS_EN ? r_sum : 16'd0;
      checks++;
      if (r_done_at !== 10 || r_cks_done !== ek) begin
         errors++;
         $display("FAIL back_to_back done_at=%0d cks=%h required 10 %h", r_done_at, r_cks_done, ek);
      end else
         $display("overlapping copy after fill ok");
      checks++;
      if (mem[25] !== 16'h8001 || mem[26] !== 16'h8001 || mem[27] !== 16'h8001) begin
         errors++;
         $display("FAIL overlap_mem got=%h %h %h required 8001 x3", mem[25], mem[26], mem[27]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      for (int k = 0; k < 32; k++) preload(5'(k), 16'h1000 + 16'(k));
      test_copy();
      test_fill_wrap();
      test_zero_length();
      test_clamp();
      test_ignore_start();
      test_rst_mid_copy();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_writes pending=%0d required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uint16_ram_mover.md
UINT16_RAM_MOVER -- requirements
Module: uint16_ram_mover

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: start  in  1  command strobe, sampled only in IDLE.
REQ-004 SHALL: op  in  1  0 = FILL, 1 = COPY; sampled with start.
REQ-005 SHALL: src  in  16 (UInt16)  COPY source base address; sampled with start.
REQ-006 SHALL: dst  in  16 (UInt16)  destination base address; sampled with start.
REQ-007 SHALL: length  in  6  word count; sampled with start; values 33..63 clamp to 32.
REQ-008 SHALL: fill_value  in  16 (UInt16)  FILL data; sampled with start.
REQ-009 SHALL: busy  out  1  high in every state except IDLE.
REQ-010 SHALL: done  out  1  one-cycle completion pulse.
REQ-011 SHALL: checksum  out  16 (UInt16)  running sum of transferred words.
REQ-012 SHALL: ram_address  out  16 (UInt16)  RAM address; the RAM decodes bits [4:0].
REQ-013 SHALL: ram_read, ram_write  out  1 each  RAM strobes, never both high in one cycle.
REQ-014 SHALL: ram_input_data  out  16 (UInt16)  RAM write data.
REQ-015 SHALL: ram_output_data  in  16 (UInt16)  RAM read data, valid the cycle after ram_read, 0 otherwise.

Function
REQ-016 SHALL: states IDLE, FILL_WR, CP_RD, CP_CAP, CP_WR, DONE; all outputs registered (Moore).
REQ-017 SHALL: IDLE with start=1 latches the command, clears the word index i to 0, and enters DONE if the clamped length is 0, else FILL_WR (op=0) or CP_RD (op=1).
REQ-018 SHALL: FILL_WR drives ram_write=1, ram_address=dst+i, ram_input_data=fill_value; increments i; after the last word, enters DONE.
REQ-019 SHALL: CP_RD drives ram_read=1, ram_address=src+i; then CP_CAP.
REQ-020 SHALL: CP_CAP drives both strobes to 0; at its closing edge, ram_output_data is captured into a hold register; then CP_WR.
REQ-021 SHALL: CP_WR drives ram_write=1, ram_address=dst+i, ram_input_data=hold; increments i; then CP_RD, or DONE after the last word.
REQ-022 SHALL: address arithmetic is 16-bit modulo 2^16; the full sum is presented on ram_address, so the RAM wraps at 32 words.
REQ-023 SHALL: COPY processes ascending i; overlapping ranges with dst>src propagate earlier writes (defined behaviour, no hazard detection).
REQ-024 SHALL: DONE lasts exactly one cycle with done=1 and busy=0, then returns to IDLE; start during DONE is ignored.
REQ-025 SHALL: start while busy is ignored and does not alter the latched command.
REQ-026 SHALL: FILL of N words takes N cycles of busy; COPY of N words takes 3N cycles of busy; done follows the last write cycle.
REQ-027 SHALL: in IDLE and DONE, ram_read=ram_write=0, ram_address=0 and ram_input_data=0.

Reset
REQ-028 SHALL: rst=1 at an edge forces IDLE, i=0, hold=0, checksum=0, and drives every output to 0, including during a transfer; no RAM strobe occurs in the cycle after reset.
REQ-029 SHALL: rst has priority over start.

Configuration
REQ-030 SHALL: with CHECKSUM_EN defined, checksum clears on an accepted start and adds each written word (fill_value, or the captured word) modulo 2^16 at each write edge; it holds its value after DONE until the next start.
REQ-031 SHALL: without CHECKSUM_EN, checksum is tied to 0 and no accumulator is synthesized.

Verification
REQ-032 SHALL: FILL dst=30, length=4, fill_value=0xABCD -> writes to addresses 30,31,32,33 (RAM words 30,31,0,1); done in cycle 5 after start; checksum=0xAF34 with CHECKSUM_EN.
REQ-033 SHALL: preload words 0..2 = 1,2,3; COPY src=0, dst=8, length=3 -> words 8..10 = 1,2,3; busy for 9 cycles; done once; checksum=6.
REQ-034 SHALL: length=0 with any op -> no strobes; done=1 in the cycle after start.
REQ-035 SHALL: length=40 FILL -> exactly 32 write cycles.
REQ-036 SHALL: start pulsed again mid-COPY -> ignored; first command completes unchanged.
REQ-037 SHALL: rst asserted during CP_CAP -> next cycle all outputs 0 and state IDLE; a following FILL length=1 executes normally.
